// File: rtl/router_sync.sv
// router_sync: latches the packet destination, steers writes to one of three FIFOs, and flushes FIFOs left unread too long
module router_sync #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       detect_add,
  input  logic [1:0] data_in,
  input  logic       write_enb_reg,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  output logic [2:0] write_enb,
  output logic       fifo_full,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
  logic [1:0]            addr_q, addr_d;
  logic [2:0]            vld, rd, soft_reset_q, soft_reset_d;
  logic [3:0]            full_v, sel;
  logic [2:0][CNT_W-1:0] timer_q, timer_d;
  assign vld          = ~{empty_2, empty_1, empty_0};
  assign rd           = {read_enb_2, read_enb_1, read_enb_0};
  assign full_v       = {1'b0, full_2, full_1, full_0};
  assign sel          = 4'b0001 << addr_q;
  assign vld_out_0    = vld[0];
  assign vld_out_1    = vld[1];
  assign vld_out_2    = vld[2];
  assign soft_reset_0 = soft_reset_q[0];
  assign soft_reset_1 = soft_reset_q[1];
  assign soft_reset_2 = soft_reset_q[2];
  // capture the header destination; address 11 maps to no FIFO and never reports full
  always_comb begin
    addr_d    = detect_add ? data_in : addr_q;
    write_enb = write_enb_reg ? sel[2:0] : 3'b000;
    fifo_full = full_v[addr_q];
  end
  // per-port idle timers: count unread valid cycles and pulse soft reset on the last one
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      timer_d[i]      = (vld[i] && !rd[i] && timer_q[i] != LAST) ? timer_q[i] + 1'b1 : '0;
      soft_reset_d[i] = vld[i] && !rd[i] && timer_q[i] == LAST;
    end
  end
  // state registers; reset parks the address on the invalid port and drops any pending flush
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q       <= 2'b11;
      timer_q      <= '0;
      soft_reset_q <= '0;
    end else begin
      addr_q       <= addr_d;
      timer_q      <= timer_d;
      soft_reset_q <= soft_reset_d;
    end
  end
endmodule

// File: tb/tb_router_sync.sv
// tb_router_sync: directed vector table for steering plus hand sequences for the timeout behaviour
module tb_router_sync;
  logic       clock = 1'b0, resetn, detect_add, write_enb_reg;
  logic [1:0] data_in;
  logic [2:0] rdn, emp, fl, write_enb;
  logic       fifo_full, vld_out_0, vld_out_1, vld_out_2, soft_reset_0, soft_reset_1, soft_reset_2;
  int         total = 0, bad = 0;
  typedef struct {
    logic       det;
    logic [1:0] data;
    logic       wr;
    logic [2:0] full;
    logic [2:0] empty;
    logic [2:0] we;
    logic       ff;
    logic [2:0] vld;
  } vec_t;
  vec_t vt[14];

  router_sync dut (
    .clock(clock), .resetn(resetn), .detect_add(detect_add), .data_in(data_in),
    .write_enb_reg(write_enb_reg),
    .read_enb_0(rdn[0]), .read_enb_1(rdn[1]), .read_enb_2(rdn[2]),
    .empty_0(emp[0]), .empty_1(emp[1]), .empty_2(emp[2]),
    .full_0(fl[0]), .full_1(fl[1]), .full_2(fl[2]),
    .write_enb(write_enb), .fifo_full(fifo_full),
    .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [2:0] sr();
    return {soft_reset_2, soft_reset_1, soft_reset_0};
  endfunction

  initial begin
    vt[0]  = '{1'b0, 2'b00, 1'b1, 3'b111, 3'b000, 3'b000, 1'b0, 3'b111};
    vt[1]  = '{1'b1, 2'b01, 1'b0, 3'b000, 3'b001, 3'b000, 1'b0, 3'b110};
    vt[2]  = '{1'b0, 2'b00, 1'b1, 3'b000, 3'b010, 3'b010, 1'b0, 3'b101};
    vt[3]  = '{1'b0, 2'b00, 1'b1, 3'b010, 3'b100, 3'b010, 1'b1, 3'b011};
    vt[4]  = '{1'b0, 2'b00, 1'b1, 3'b001, 3'b111, 3'b010, 1'b0, 3'b000};
    vt[5]  = '{1'b1, 2'b00, 1'b1, 3'b101, 3'b011, 3'b010, 1'b0, 3'b100};
    vt[6]  = '{1'b0, 2'b00, 1'b1, 3'b001, 3'b000, 3'b001, 1'b1, 3'b111};
    vt[7]  = '{1'b1, 2'b10, 1'b1, 3'b000, 3'b110, 3'b001, 1'b0, 3'b001};
    vt[8]  = '{1'b0, 2'b00, 1'b1, 3'b100, 3'b101, 3'b100, 1'b1, 3'b010};
    vt[9]  = '{1'b0, 2'b00, 1'b0, 3'b111, 3'b111, 3'b000, 1'b1, 3'b000};
    vt[10] = '{1'b1, 2'b11, 1'b1, 3'b111, 3'b000, 3'b100, 1'b1, 3'b111};
    vt[11] = '{1'b0, 2'b00, 1'b1, 3'b111, 3'b010, 3'b000, 1'b0, 3'b101};
    vt[12] = '{1'b1, 2'b10, 1'b0, 3'b000, 3'b001, 3'b000, 1'b0, 3'b110};
    vt[13] = '{1'b0, 2'b00, 1'b1, 3'b011, 3'b100, 3'b100, 1'b0, 3'b011};

    resetn = 1'b0; detect_add = 1'b0; data_in = 2'b00; write_enb_reg = 1'b1;
    rdn = 3'b000; emp = 3'b010; fl = 3'b111;
    #12;
    chk("rst_we", 8'(write_enb), 8'h00);
    chk("rst_ff", 8'(fifo_full), 8'h00);
    chk("rst_vld", 8'({vld_out_2, vld_out_1, vld_out_0}), 8'h05);
    chk("rst_sr", 8'(sr()), 8'h00);
    #1 resetn = 1'b1;
    rdn = 3'b111;
    step();
    chk("post_rst_addr11_we", 8'(write_enb), 8'h00);

    for (int i = 0; i < 14; i++) begin
      detect_add = vt[i].det; data_in = vt[i].data; write_enb_reg = vt[i].wr;
      fl = vt[i].full; emp = vt[i].empty;
      #1;
      chk($sformatf("vec%0d_we", i), 8'(write_enb), 8'(vt[i].we));
      chk($sformatf("vec%0d_ff", i), 8'(fifo_full), 8'(vt[i].ff));
      chk($sformatf("vec%0d_vld", i), 8'({vld_out_2, vld_out_1, vld_out_0}), 8'(vt[i].vld));
      chk($sformatf("vec%0d_sr", i), 8'(sr()), 8'h00);
      step();
    end
    detect_add = 1'b0;

    write_enb_reg = 1'b1; fl = 3'b100; emp = 3'b000; rdn = 3'b000;
    for (int k = 0; k < 20; k++) step();
    chk("mid_pre_we", 8'(write_enb), 8'h04);
    chk("mid_pre_ff", 8'(fifo_full), 8'h01);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_we", 8'(write_enb), 8'h00);
    chk("mid_rst_ff", 8'(fifo_full), 8'h00);
    chk("mid_rst_sr", 8'(sr()), 8'h00);
    step();
    resetn = 1'b1; write_enb_reg = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      step();
      chk($sformatf("after_rst_sr_e%0d", k), 8'(sr()), (k == 30) ? 8'h07 : 8'h00);
    end
    emp = 3'b111;
    step();

    emp = 3'b110;
    for (int k = 1; k <= 60; k++) begin
      step();
      chk($sformatf("p0_timeout_e%0d", k), 8'(sr()), (k == 30 || k == 60) ? 8'h01 : 8'h00);
    end
    emp = 3'b111;
    step();

    emp = 3'b011;
    for (int k = 1; k <= 29; k++) begin
      step();
      chk($sformatf("p2_pre_read_e%0d", k), 8'(sr()), 8'h00);
    end
    rdn[2] = 1'b1;
    step();
    chk("p2_read_at_29", 8'(sr()), 8'h00);
    rdn[2] = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      step();
      chk($sformatf("p2_post_read_e%0d", k), 8'(sr()), (k == 30) ? 8'h04 : 8'h00);
    end
    emp = 3'b111;
    step();

    emp = 3'b000; rdn = 3'b101;
    for (int k = 1; k <= 40; k++) begin
      rdn[0] = (k <= 5);
      step();
      chk($sformatf("multi_e%0d", k), 8'(sr()),
          (k == 30) ? 8'h02 : (k == 35) ? 8'h01 : 8'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
